// File: rtl/ram_controller.sv
// ram_controller: word-addressed memory back end answering single-pulse requests after LATENCY cycles.
// Optional refresh-window stalls are compiled in with RAM_CONTROLLER_REFRESH_EN.
module ram_controller #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned LATENCY        = 4,
  parameter int unsigned REFRESH_PERIOD = 64,
  parameter int unsigned REFRESH_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [31:0]              ram_data_wr,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_data_valid,
  output logic                     ram_busy,
  output logic                     protocol_err
);

  localparam int unsigned IDX_W     = ADDRESS_WIDTH - 2;
  localparam int unsigned MEM_WORDS = 2 ** IDX_W;
`ifdef RAM_CONTROLLER_REFRESH_EN
  localparam int unsigned CNT_MAX = (LATENCY > REFRESH_CYCLES) ? LATENCY : REFRESH_CYCLES;
`else
  localparam int unsigned CNT_MAX = LATENCY;
  localparam int unsigned unused_refresh_cfg = REFRESH_PERIOD + REFRESH_CYCLES;
`endif
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  typedef struct packed {
    logic             we;
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
  } req_t;

  typedef enum logic [1:0] {
    StIdle,
`ifdef RAM_CONTROLLER_REFRESH_EN
    StRefresh,
`endif
    StAccess
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  req_t             req_q, req_d;
  logic             valid_q, valid_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             err_q, err_d;

  logic [31:0] mem [MEM_WORDS];

  logic req_in, start, done;
  req_t in_op, start_op, done_op;
  logic [1:0] unused_addr_bits;

  assign unused_addr_bits = ram_address[1:0];
  assign req_in           = ram_rd | ram_wr;
  assign in_op.we         = ram_wr;
  assign in_op.idx        = ram_address[ADDRESS_WIDTH-1:2];
  assign in_op.data       = ram_data_wr;

`ifdef RAM_CONTROLLER_REFRESH_EN
  localparam int unsigned REF_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
  logic             ref_pend_q, ref_pend_d, ref_done, ref_wrap;
  logic             hold_vld_q, hold_vld_d;
  req_t             hold_q, hold_d;

  assign ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_PERIOD - 1));
  assign ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    valid_d   = 1'b0;
    rd_data_d = rd_data_q;
    err_d     = err_q | (ram_rd & ram_wr);
    start     = 1'b0;
    start_op  = in_op;
    done      = 1'b0;
    done_op   = req_q;
`ifdef RAM_CONTROLLER_REFRESH_EN
    ref_done   = 1'b0;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
`endif

    unique case (state_q)
      StIdle: begin
`ifdef RAM_CONTROLLER_REFRESH_EN
        // Refresh wins over a same-cycle request, which waits in the hold register.
        if (ref_pend_q) begin
          state_d = StRefresh;
          cnt_d   = CNT_W'(REFRESH_CYCLES - 1);
          if (req_in) begin
            hold_vld_d = 1'b1;
            hold_d     = in_op;
          end
        end else
`endif
        if (req_in) start = 1'b1;
      end
      StAccess: begin
        if (req_in) err_d = 1'b1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end
`ifdef RAM_CONTROLLER_REFRESH_EN
      StRefresh: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          ref_done = 1'b1;
          state_d  = StIdle;
          if (hold_vld_q) begin
            start      = 1'b1;
            start_op   = hold_q;
            hold_vld_d = 1'b0;
            if (req_in) err_d = 1'b1;
          end else if (req_in) begin
            start = 1'b1;
          end
        end else if (req_in) begin
          if (hold_vld_q) begin
            err_d = 1'b1;
          end else begin
            hold_vld_d = 1'b1;
            hold_d     = in_op;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // A single-cycle latency completes on the accepting edge without visiting ACCESS.
    if (start) begin
      if (LATENCY == 1) begin
        done    = 1'b1;
        done_op = start_op;
      end else begin
        state_d = StAccess;
        cnt_d   = CNT_W'(LATENCY - 1);
        req_d   = start_op;
      end
    end

    if (done) begin
      valid_d = 1'b1;
      if (!done_op.we) rd_data_d = mem[done_op.idx];
    end

`ifdef RAM_CONTROLLER_REFRESH_EN
    ref_pend_d = ref_done ? 1'b0 : (ref_pend_q | ref_wrap);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      req_q     <= '0;
      valid_q   <= 1'b0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
`ifdef RAM_CONTROLLER_REFRESH_EN
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
`ifdef RAM_CONTROLLER_REFRESH_EN
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
`endif
    end
  end

  // Array is never reset; a write in flight during reset is abandoned.
  always_ff @(posedge clk) begin
    if (rst && done && done_op.we) mem[done_op.idx] <= done_op.data;
  end

  assign ram_data_rd    = rd_data_q;
  assign ram_data_valid = valid_q;
  assign ram_busy       = (state_q != StIdle);
  assign protocol_err   = err_q;

endmodule
